// File: rtl/fifo_chk_pkg.sv
// ============================================================================
// Module   : fifo_chk_pkg
// Purpose  : Shared error codes, defaults and width helpers for the
//            multi-channel FIFO checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_chk_pkg;

    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int N_ERR           = 5;

    typedef enum logic [2:0] {
        ERR_PUSH_FULL  = 3'd0,
        ERR_POP_EMPTY  = 3'd1,
        ERR_FLAG_MUTEX = 3'd2,
        ERR_FLAG_MODEL = 3'd3,
        ERR_DATA       = 3'd4
    } err_code_e;

    function automatic int chan_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_chk_lane.sv
// ============================================================================
// Module   : fifo_chk_lane
// Purpose  : Shadow model and per-cycle checks for one snooped FIFO channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_chk_lane
    import fifo_chk_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     full,
    input  logic                     empty,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     clr,
    output logic [N_ERR-1:0]         err,
    output logic [cnt_w(DEPTH)-1:0]  hwm
);

    localparam int                 c_CNT_W    = cnt_w(DEPTH);
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_d [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]    r_cnt_q, w_cnt_d;
    logic [c_CNT_W-1:0]    r_hwm_q, w_hwm_d;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_data_err;

    // Count guards keep the shadow consistent even when the DUT flags lie.
    assign w_push_ok = wr_en & ~full & (r_cnt_q < c_FULL_CNT);
    assign w_pop_ok  = rd_en & ~empty & (r_cnt_q != '0);
    assign w_head    = r_mem_q[r_rd_ptr_q];
    assign hwm       = r_hwm_q;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_cnt_d    = r_cnt_q;
        if (w_push_ok) begin
            w_mem_d[r_wr_ptr_q] = wr_data;
            w_wr_ptr_d = (r_wr_ptr_q == c_LAST_PTR) ? '0 : r_wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_LAST_PTR) ? '0 : r_rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_cnt_d = r_cnt_q + 1'b1;
            2'b01:   w_cnt_d = r_cnt_q - 1'b1;
            default: w_cnt_d = r_cnt_q;
        endcase
        if (clr) begin
            w_hwm_d = '0;
        end else begin
            w_hwm_d = (r_cnt_q > r_hwm_q) ? r_cnt_q : r_hwm_q;
        end
    end

    always_comb begin
        err                 = '0;
        err[ERR_PUSH_FULL]  = wr_en & full;
        err[ERR_POP_EMPTY]  = rd_en & empty;
        err[ERR_FLAG_MUTEX] = full & empty;
        err[ERR_FLAG_MODEL] = (empty != (r_cnt_q == '0)) | (full != (r_cnt_q == c_FULL_CNT));
        err[ERR_DATA]       = w_data_err;
    end

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign w_data_err = w_pop_ok & (rd_data != w_head);
        end else begin : g_lat1
            // Head is captured at the pop and checked when rd_data arrives.
            logic                  r_pend_q, w_pend_d;
            logic [DATA_WIDTH-1:0] r_exp_q, w_exp_d;

            always_comb begin
                w_pend_d = w_pop_ok;
                w_exp_d  = w_pop_ok ? w_head : r_exp_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pend_q <= 1'b0;
                    r_exp_q  <= '0;
                end else begin
                    r_pend_q <= w_pend_d;
                    r_exp_q  <= w_exp_d;
                end
            end

            assign w_data_err = r_pend_q & (rd_data != r_exp_q);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_cnt_q    <= '0;
            r_hwm_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_cnt_q    <= w_cnt_d;
            r_hwm_q    <= w_hwm_d;
        end
    end

    // Storage is only read behind a non-zero count, so it needs no reset.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/fifo_scoreboard_mc.sv
// ============================================================================
// Module   : fifo_scoreboard_mc
// Purpose  : Multi-channel black-box FIFO checker with registered error
//            reporting, sticky flags, saturating counter and high-watermarks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_scoreboard_mc
    import fifo_chk_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 wr_en,
    input  logic [NUM_CH-1:0]                 rd_en,
    input  logic [NUM_CH-1:0]                 full,
    input  logic [NUM_CH-1:0]                 empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      wr_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      rd_data,
    input  logic                              clr,
    output logic                              err_valid,
    output logic [2:0]                        err_code,
    output logic [chan_w(NUM_CH)-1:0]         err_chan,
    output logic [N_ERR-1:0]                  err_flags,
    output logic [ERR_CNT_W-1:0]              err_count,
    output logic [2:0]                        first_err_code,
    output logic [chan_w(NUM_CH)-1:0]         first_err_chan,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0]    hwm
);

    localparam int c_CH_W  = chan_w(NUM_CH);
    localparam int c_CNT_W = cnt_w(DEPTH);

    logic [N_ERR-1:0]     w_lane_err [NUM_CH];
    logic                 w_any;
    logic [2:0]           w_code;
    logic [c_CH_W-1:0]    w_chan;
    logic [N_ERR-1:0]     w_code_or;
    logic [ERR_CNT_W:0]   w_pop;
    logic [ERR_CNT_W:0]   w_sum;

    logic                 r_err_valid_q, w_err_valid_d;
    logic [2:0]           r_err_code_q, w_err_code_d;
    logic [c_CH_W-1:0]    r_err_chan_q, w_err_chan_d;
    logic [N_ERR-1:0]     r_err_flags_q, w_err_flags_d;
    logic [ERR_CNT_W-1:0] r_err_count_q, w_err_count_d;
    logic [2:0]           r_first_code_q, w_first_code_d;
    logic [c_CH_W-1:0]    r_first_chan_q, w_first_chan_d;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
            fifo_chk_lane #(
                .DEPTH      (DEPTH),
                .DATA_WIDTH (DATA_WIDTH),
                .RD_LATENCY (RD_LATENCY)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[g]),
                .rd_en   (rd_en[g]),
                .full    (full[g]),
                .empty   (empty[g]),
                .wr_data (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .rd_data (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .clr     (clr),
                .err     (w_lane_err[g]),
                .hwm     (hwm[g*c_CNT_W +: c_CNT_W])
            );
        end
    endgenerate

    // Scan code-major so the lowest code wins, then the lowest channel.
    always_comb begin
        w_any     = 1'b0;
        w_code    = '0;
        w_chan    = '0;
        w_code_or = '0;
        w_pop     = '0;
        for (int k = 0; k < N_ERR; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_lane_err[c][k]) begin
                    if (!w_any) begin
                        w_code = 3'(k);
                        w_chan = c_CH_W'(c);
                    end
                    w_any        = 1'b1;
                    w_code_or[k] = 1'b1;
                    w_pop        = w_pop + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sum          = {1'b0, r_err_count_q} + w_pop;
        w_err_valid_d  = w_any;
        w_err_code_d   = w_code;
        w_err_chan_d   = w_chan;
        w_err_flags_d  = r_err_flags_q | w_code_or;
        w_err_count_d  = w_sum[ERR_CNT_W] ? '1 : w_sum[ERR_CNT_W-1:0];
        w_first_code_d = r_first_code_q;
        w_first_chan_d = r_first_chan_q;
        // Empty sticky flags mean nothing has been recorded since reset/clr.
        if (w_any && (r_err_flags_q == '0)) begin
            w_first_code_d = w_code;
            w_first_chan_d = w_chan;
        end
        if (clr) begin
            w_err_flags_d  = '0;
            w_err_count_d  = '0;
            w_first_code_d = '0;
            w_first_chan_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_valid_q  <= 1'b0;
            r_err_code_q   <= '0;
            r_err_chan_q   <= '0;
            r_err_flags_q  <= '0;
            r_err_count_q  <= '0;
            r_first_code_q <= '0;
            r_first_chan_q <= '0;
        end else begin
            r_err_valid_q  <= w_err_valid_d;
            r_err_code_q   <= w_err_code_d;
            r_err_chan_q   <= w_err_chan_d;
            r_err_flags_q  <= w_err_flags_d;
            r_err_count_q  <= w_err_count_d;
            r_first_code_q <= w_first_code_d;
            r_first_chan_q <= w_first_chan_d;
        end
    end

    assign err_valid      = r_err_valid_q;
    assign err_code       = r_err_code_q;
    assign err_chan       = r_err_chan_q;
    assign err_flags      = r_err_flags_q;
    assign err_count      = r_err_count_q;
    assign first_err_code = r_first_code_q;
    assign first_err_chan = r_first_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_scoreboard_mc.sv
// ============================================================================
// Module   : tb_fifo_scoreboard_mc
// Purpose  : Self-checking bench for fifo_scoreboard_mc (latency 1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_scoreboard_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  wr_en = '0, rd_en = '0, full = '0, empty = '0;
    logic [15:0] wr_data = '0, rd_data = '0, rd_data_l0 = '0;

    logic        err_valid, d0_err_valid;
    logic [2:0]  err_code, d0_err_code, first_err_code, d0_first_err_code;
    logic [1:0]  err_chan, d0_err_chan, first_err_chan, d0_first_err_chan;
    logic [4:0]  err_flags, d0_err_flags;
    logic [15:0] err_count, d0_err_count;
    logic [5:0]  hwm, d0_hwm;

    always #5 clk = ~clk;

    fifo_scoreboard_mc #(.NUM_CH(2), .DEPTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .full(full), .empty(empty),
        .wr_data(wr_data), .rd_data(rd_data), .clr(clr),
        .err_valid(err_valid), .err_code(err_code), .err_chan(err_chan), .err_flags(err_flags),
        .err_count(err_count), .first_err_code(first_err_code), .first_err_chan(first_err_chan),
        .hwm(hwm)
    );

    fifo_scoreboard_mc #(.NUM_CH(2), .DEPTH(4), .DATA_WIDTH(8), .RD_LATENCY(0), .ERR_CNT_W(16)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .full(full), .empty(empty),
        .wr_data(wr_data), .rd_data(rd_data_l0), .clr(clr),
        .err_valid(d0_err_valid), .err_code(d0_err_code), .err_chan(d0_err_chan),
        .err_flags(d0_err_flags), .err_count(d0_err_count), .first_err_code(d0_first_err_code),
        .first_err_chan(d0_first_err_chan), .hwm(d0_hwm)
    );

    typedef struct packed {
        logic        v;
        logic [2:0]  code;
        logic [1:0]  chan;
        logic [4:0]  flags;
        logic [15:0] cnt;
        logic [2:0]  fcode;
        logic [1:0]  fchan;
        logic [5:0]  hwm;
    } rep_t;

    rep_t        exp_q[$];
    rep_t        act_q[$];
    logic [7:0]  m_q [2][$];
    logic [1:0]  m_pend = '0;
    logic [7:0]  m_pval [2];
    logic [4:0]  m_flags = '0;
    int          m_count = 0;
    logic [2:0]  m_fcode = '0;
    logic [1:0]  m_fchan = '0;
    int          m_hwm [2] = '{0, 0};
    logic [7:0]  vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    int n_chk = 0;
    int n_fail = 0;

    // Reference model of the latency-1 checker: predicts the report, then clocks.
    task automatic tick();
        rep_t       e;
        rep_t       a;
        logic [4:0] ev [2];
        int         n [2];
        int         pc;
        logic       found;
        e = '0;
        if (!rst_n) begin
            m_q[0].delete();
            m_q[1].delete();
            m_pend  = '0;
            m_flags = '0;
            m_count = 0;
            m_fcode = '0;
            m_fchan = '0;
            m_hwm   = '{0, 0};
        end else begin
            for (int c = 0; c < 2; c++) begin
                n[c]     = m_q[c].size();
                ev[c][0] = wr_en[c] & full[c];
                ev[c][1] = rd_en[c] & empty[c];
                ev[c][2] = full[c] & empty[c];
                ev[c][3] = (empty[c] != (n[c] == 0)) || (full[c] != (n[c] == 4));
                ev[c][4] = m_pend[c] && (rd_data[c*8 +: 8] != m_pval[c]);
            end
            found = 1'b0;
            pc    = 0;
            for (int k = 0; k < 5; k++) begin
                for (int c = 0; c < 2; c++) begin
                    if (ev[c][k]) begin
                        if (!found) begin
                            e.code = 3'(k);
                            e.chan = 2'(c);
                        end
                        found = 1'b1;
                        pc++;
                    end
                end
            end
            e.v = found;
            if (clr) begin
                m_flags = '0;
                m_count = 0;
                m_fcode = '0;
                m_fchan = '0;
            end else begin
                if (found && m_flags == '0) begin
                    m_fcode = e.code;
                    m_fchan = e.chan;
                end
                m_flags = m_flags | ev[0] | ev[1];
                m_count = (m_count + pc > 65535) ? 65535 : m_count + pc;
            end
            for (int c = 0; c < 2; c++) begin
                if (clr)               m_hwm[c] = 0;
                else if (n[c] > m_hwm[c]) m_hwm[c] = n[c];
                m_pend[c] = rd_en[c] && !empty[c] && (n[c] > 0);
                if (m_pend[c]) m_pval[c] = m_q[c].pop_front();
                if (wr_en[c] && !full[c] && (n[c] < 4)) m_q[c].push_back(wr_data[c*8 +: 8]);
            end
        end
        e.flags = m_flags;
        e.cnt   = 16'(m_count);
        e.fcode = m_fcode;
        e.fchan = m_fchan;
        e.hwm   = {3'(m_hwm[1]), 3'(m_hwm[0])};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = {err_valid, err_code, err_chan, err_flags, err_count, first_err_code, first_err_chan, hwm};
        act_q.push_back(a);
    endtask

    task automatic auto_flags();
        for (int c = 0; c < 2; c++) begin
            full[c]  = (m_q[c].size() == 4);
            empty[c] = (m_q[c].size() == 0);
        end
    endtask

    task automatic drv(input logic [1:0] we, input logic [1:0] re, input logic [15:0] wd, input logic [15:0] rd);
        wr_en = we; rd_en = re; wr_data = wd; rd_data = rd; clr = 1'b0;
        auto_flags();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0;
        wr_en = '0; rd_en = '0; full = '0; empty = '0; wr_data = '0; rd_data = '0; rd_data_l0 = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rep_t e, a;
        do_reset();
        n_chk++;
        if ({err_valid, err_flags, err_count, first_err_code, first_err_chan, hwm} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b f=%b cnt=%0d hwm=%h, expected all zero", err_valid, err_flags, err_count, hwm);
        end
        n_chk++;
        if ({d0_err_valid, d0_err_flags, d0_err_count, d0_hwm} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_l0: got v=%b f=%b cnt=%0d hwm=%h, expected all zero", d0_err_valid, d0_err_flags, d0_err_count, d0_hwm);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL reset_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_fill_drain();
        rep_t e, a;
        do_reset();
        for (int i = 0; i < 4; i++) drv(2'b01, 2'b00, {8'h00, vals[i]}, '0);
        for (int i = 0; i < 5; i++) drv(2'b00, (i < 4) ? 2'b01 : 2'b00, '0, (i > 0) ? {8'h00, vals[i-1]} : 16'h0000);
        drv(2'b00, 2'b00, '0, '0);
        n_chk++;
        if ({err_flags, err_count, hwm[2:0]} !== {5'b0, 16'd0, 3'd4}) begin
            n_fail++;
            $display("FAIL fill_drain_end: got flags=%b cnt=%0d hwm0=%0d, expected 0/0/4", err_flags, err_count, hwm[2:0]);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL fill_drain_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_data_err();
        rep_t e, a;
        do_reset();
        drv(2'b10, 2'b00, 16'hA500, '0);
        drv(2'b00, 2'b10, '0, '0);
        drv(2'b00, 2'b00, '0, 16'h5A00);
        n_chk++;
        if ({err_valid, err_code, err_chan, err_flags, err_count, first_err_code, first_err_chan}
            !== {1'b1, 3'd4, 2'd1, 5'b10000, 16'd1, 3'd4, 2'd1}) begin
            n_fail++;
            $display("FAIL data_err: got v=%b code=%0d chan=%0d flags=%b cnt=%0d, expected 1/4/1/10000/1",
                     err_valid, err_code, err_chan, err_flags, err_count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL data_err_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_illegal_ops();
        rep_t e, a;
        do_reset();
        for (int i = 0; i < 4; i++) drv(2'b01, 2'b00, {8'h00, vals[i]}, '0);
        drv(2'b01, 2'b10, 16'h0099, '0);
        n_chk++;
        if ({err_valid, err_code, err_chan, err_flags, err_count} !== {1'b1, 3'd0, 2'd0, 5'b00011, 16'd2}) begin
            n_fail++;
            $display("FAIL illegal_ops: got v=%b code=%0d chan=%0d flags=%b cnt=%0d, expected 1/0/0/00011/2",
                     err_valid, err_code, err_chan, err_flags, err_count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL illegal_ops_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_flag_model();
        rep_t e, a;
        do_reset();
        for (int i = 0; i < 3; i++) drv(2'b01, 2'b00, {8'h00, vals[i]}, '0);
        wr_en = 2'b00; rd_en = 2'b00; full = 2'b01; empty = 2'b10;
        tick();
        n_chk++;
        if ({err_valid, err_code, err_chan} !== {1'b1, 3'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL flag_model: got v=%b code=%0d chan=%0d, expected 1/3/0", err_valid, err_code, err_chan);
        end
        wr_en = 2'b01; wr_data = 16'h0055;
        tick();
        n_chk++;
        if ({err_valid, err_code, err_chan} !== {1'b1, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL flag_model_push: got v=%b code=%0d chan=%0d, expected 1/0/0", err_valid, err_code, err_chan);
        end
        drv(2'b00, 2'b00, '0, '0);
        n_chk++;
        if ({err_valid, hwm[2:0]} !== {1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL flag_model_cnt3: got v=%b hwm0=%0d, expected 0/3", err_valid, hwm[2:0]);
        end
        for (int i = 0; i < 4; i++) drv(2'b00, (i < 3) ? 2'b01 : 2'b00, '0, (i > 0) ? {8'h00, vals[i-1]} : 16'h0000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL flag_model_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_simul_clr();
        rep_t e, a;
        do_reset();
        for (int i = 0; i < 4; i++) drv(2'b01, 2'b00, {8'h00, vals[i]}, '0);
        drv(2'b01, 2'b01, 16'h0077, '0);
        n_chk++;
        if ({err_valid, err_code, err_chan} !== {1'b1, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL simul_push_full: got v=%b code=%0d chan=%0d, expected 1/0/0", err_valid, err_code, err_chan);
        end
        wr_en = '0; rd_en = '0; wr_data = '0; rd_data = 16'h0011; clr = 1'b1;
        auto_flags();
        tick();
        n_chk++;
        if ({err_valid, err_flags, err_count, hwm} !== '0) begin
            n_fail++;
            $display("FAIL simul_clr: got v=%b flags=%b cnt=%0d hwm=%h, expected all zero", err_valid, err_flags, err_count, hwm);
        end
        rd_en = 2'b10; rd_data = '0; clr = 1'b1;
        auto_flags();
        tick();
        n_chk++;
        if ({err_valid, err_code, err_chan, err_flags, err_count, first_err_code, first_err_chan}
            !== {1'b1, 3'd1, 2'd1, 5'b0, 16'd0, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL clr_wins: got v=%b code=%0d chan=%0d flags=%b cnt=%0d, expected 1/1/1/0/0",
                     err_valid, err_code, err_chan, err_flags, err_count);
        end
        for (int i = 1; i < 5; i++) drv(2'b00, (i < 4) ? 2'b01 : 2'b00, '0, (i > 1) ? {8'h00, vals[i-1]} : 16'h0000);
        n_chk++;
        if ({err_valid, err_count} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL simul_tail: got v=%b cnt=%0d, expected 0/0", err_valid, err_count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL simul_clr_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_reset_pending();
        rep_t e, a;
        do_reset();
        drv(2'b01, 2'b00, 16'h005A, '0);
        drv(2'b00, 2'b01, '0, '0);
        rst_n = 1'b0; wr_en = '0; rd_en = '0; full = '0; empty = '0; rd_data = 16'h00FF;
        tick();
        n_chk++;
        if ({err_valid, err_flags, err_count, first_err_code, first_err_chan, hwm} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b flags=%b cnt=%0d hwm=%h, expected all zero", err_valid, err_flags, err_count, hwm);
        end
        rst_n = 1'b1;
        drv(2'b00, 2'b00, '0, 16'h00FF);
        n_chk++;
        if (err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop_pending: got v=%b, expected 0", err_valid);
        end
        drv(2'b01, 2'b00, 16'h003C, '0);
        drv(2'b00, 2'b01, '0, '0);
        drv(2'b00, 2'b00, '0, 16'h003C);
        n_chk++;
        if ({err_valid, err_count} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_post_pop: got v=%b cnt=%0d, expected 0/0", err_valid, err_count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL reset_pending_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_latency0();
        rep_t e, a;
        do_reset();
        for (int i = 0; i < 4; i++) drv(2'b01, 2'b00, {8'h00, vals[i]}, '0);
        for (int i = 0; i < 5; i++) begin
            rd_data_l0 = (i < 4) ? {8'h00, vals[i]} : 16'h0000;
            drv(2'b00, (i < 4) ? 2'b01 : 2'b00, '0, (i > 0) ? {8'h00, vals[i-1]} : 16'h0000);
            n_chk++;
            if (d0_err_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL lat0_pop%0d: got v=%b code=%0d, expected no error", i, d0_err_valid, d0_err_code);
            end
        end
        n_chk++;
        if ({d0_hwm[2:0], d0_err_count} !== {3'd4, 16'd0}) begin
            n_fail++;
            $display("FAIL lat0_hwm: got hwm0=%0d cnt=%0d, expected 4/0", d0_hwm[2:0], d0_err_count);
        end
        drv(2'b01, 2'b00, 16'h0099, '0);
        rd_data_l0 = 16'h0098;
        drv(2'b00, 2'b01, '0, '0);
        n_chk++;
        if ({d0_err_valid, d0_err_code, d0_err_chan} !== {1'b1, 3'd4, 2'd0}) begin
            n_fail++;
            $display("FAIL lat0_data: got v=%b code=%0d chan=%0d, expected 1/4/0", d0_err_valid, d0_err_code, d0_err_chan);
        end
        rd_data_l0 = '0;
        drv(2'b00, 2'b00, '0, 16'h0099);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
            if (a !== e) begin n_fail++; $display("FAIL lat0_sb: got %h expected %h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_data_err();
        test_illegal_ops();
        test_flag_model();
        test_simul_clr();
        test_reset_pending();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
